// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int XLEN    = 32;
    localparam int WMASK_W = 8;

    localparam logic PORT_IFU = 1'b0;
    localparam logic PORT_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_arb_if.sv
// One requester channel: valid/ready request plus valid/ready response.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [XLEN-1:0]    req_addr;
    logic               req_wen;
    logic [XLEN-1:0]    req_wdata;
    logic [WMASK_W-1:0] req_wmask;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [XLEN-1:0]    rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way grant; the last-grant state lives in the parent.
module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie, round-robin favours the port that lost last time; fixed mode favours the LSU.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            if ((RR != 0) && (last_grant == PORT_LSU)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory controller between IFU (port 0) and LSU (port 1), one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DELAY = 0,
    parameter int RR    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_arb_if.slave           m0,
    mem_arb_if.slave           m1,
    output logic               mem_valid,
    output logic               mem_wen,
    output logic [XLEN-1:0]    mem_raddr,
    output logic [XLEN-1:0]    mem_waddr,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic [XLEN-1:0]    mem_rdata
);

    localparam logic [3:0] WAIT_LAST = 4'(DELAY - 1);

    arb_state_t         state;
    logic [3:0]         wait_cnt;
    logic               last_grant;
    logic               owner;
    logic               rsp_valid_q;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [XLEN-1:0]    rdata_q;
    logic [WMASK_W-1:0] wmask_q;

    logic [1:0]         req;
    logic [1:0]         grant;
    logic               handshake;
    logic               sel_id;
    logic               sel_rsp_ready;

    assign req = {m1.req_valid, m0.req_valid};

    mem_arb_rr #(.RR(RR)) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is gated by reset so a held request cannot see ready while reset is asserted.
    assign handshake    = rst_n && (state == IDLE) && (grant != 2'b00);
    assign m0.req_ready = handshake && grant[0];
    assign m1.req_ready = handshake && grant[1];
    assign sel_id       = grant[1];

    assign m0.rsp_valid = rsp_valid_q && (owner == PORT_IFU);
    assign m1.rsp_valid = rsp_valid_q && (owner == PORT_LSU);
    assign m0.rsp_rdata = rdata_q;
    assign m1.rsp_rdata = rdata_q;
    assign sel_rsp_ready = (owner == PORT_LSU) ? m1.rsp_ready : m0.rsp_ready;

    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    // Sequencer: one access pulse per transaction, optional wait, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            last_grant  <= PORT_LSU;
            owner       <= PORT_IFU;
            rsp_valid_q <= 1'b0;
            mem_valid   <= 1'b0;
            mem_wen     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        addr_q     <= sel_id ? m1.req_addr  : m0.req_addr;
                        wdata_q    <= sel_id ? m1.req_wdata : m0.req_wdata;
                        wmask_q    <= sel_id ? m1.req_wmask : m0.req_wmask;
                        mem_wen    <= sel_id ? m1.req_wen   : m0.req_wen;
                        mem_valid  <= 1'b1;
                        owner      <= sel_id;
                        last_grant <= sel_id;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_valid <= 1'b0;
                    mem_wen   <= 1'b0;
                    rdata_q   <= mem_rdata;
                    wait_cnt  <= 4'd0;
                    if (DELAY > 0) begin
                        state <= WAIT;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt    <= 4'd0;
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (sel_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: A = round-robin/no delay, B = fixed priority, C = DELAY 3.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic memLoaded;

    mem_arb_if a0 ();
    mem_arb_if a1 ();
    mem_arb_if b0 ();
    mem_arb_if b1 ();
    mem_arb_if c0 ();
    mem_arb_if c1 ();

    logic        memA_valid, memA_wen, memB_valid, memB_wen, memC_valid, memC_wen;
    logic [31:0] memA_raddr, memA_waddr, memA_wdata, memA_rdata;
    logic [31:0] memB_raddr, memB_waddr, memB_wdata, memB_rdata;
    logic [31:0] memC_raddr, memC_waddr, memC_wdata, memC_rdata;
    logic [7:0]  memA_wmask, memB_wmask, memC_wmask;
    logic [31:0] memA [16];

    mem_arbiter #(.DELAY(0), .RR(1)) dutA (
        .clk(clk), .rst_n(rst_n), .m0(a0), .m1(a1),
        .mem_valid(memA_valid), .mem_wen(memA_wen), .mem_raddr(memA_raddr),
        .mem_waddr(memA_waddr), .mem_wdata(memA_wdata), .mem_wmask(memA_wmask),
        .mem_rdata(memA_rdata)
    );

    mem_arbiter #(.DELAY(0), .RR(0)) dutB (
        .clk(clk), .rst_n(rst_n), .m0(b0), .m1(b1),
        .mem_valid(memB_valid), .mem_wen(memB_wen), .mem_raddr(memB_raddr),
        .mem_waddr(memB_waddr), .mem_wdata(memB_wdata), .mem_wmask(memB_wmask),
        .mem_rdata(memB_rdata)
    );

    mem_arbiter #(.DELAY(3), .RR(1)) dutC (
        .clk(clk), .rst_n(rst_n), .m0(c0), .m1(c1),
        .mem_valid(memC_valid), .mem_wen(memC_wen), .mem_raddr(memC_raddr),
        .mem_waddr(memC_waddr), .mem_wdata(memC_wdata), .mem_wmask(memC_wmask),
        .mem_rdata(memC_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [7:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Memory A is writable; word i starts as 0x11111111*i except word 0.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 16; i++) memA[i] <= 32'h1111_1111 * i;
            memA[0] <= 32'hDEAD_BEEF;
        end else if (memA_valid && memA_wen) begin
            memA[memA_waddr[5:2]] <= mergeWord(memA[memA_waddr[5:2]], memA_wdata, memA_wmask);
        end
    end

    assign memA_rdata = memA[memA_raddr[5:2]];
    assign memB_rdata = romWord(memB_raddr);
    assign memC_rdata = romWord(memC_raddr);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic valid, input logic [31:0] addr,
                                 input logic wen, input logic [31:0] wdata, input logic [7:0] wmask);
        if (port) begin
            a1.req_valid = valid; a1.req_addr = addr; a1.req_wen = wen;
            a1.req_wdata = wdata; a1.req_wmask = wmask;
        end else begin
            a0.req_valid = valid; a0.req_addr = addr; a0.req_wen = wen;
            a0.req_wdata = wdata; a0.req_wmask = wmask;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gA;
        int gB;
        int cyc;
        logic prevA;
        logic prevB;

        checks = 0;
        failures = 0;
        memLoaded = 1'b0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        a0.rsp_ready = 1'b1; a1.rsp_ready = 1'b1;
        b0.req_valid = 1'b0; b0.req_addr = 32'h0; b0.req_wen = 1'b0; b0.req_wdata = 32'h0;
        b0.req_wmask = 8'h0; b0.rsp_ready = 1'b1;
        b1.req_valid = 1'b0; b1.req_addr = 32'h0; b1.req_wen = 1'b0; b1.req_wdata = 32'h0;
        b1.req_wmask = 8'h0; b1.rsp_ready = 1'b1;
        c0.req_valid = 1'b0; c0.req_addr = 32'h0; c0.req_wen = 1'b0; c0.req_wdata = 32'h0;
        c0.req_wmask = 8'h0; c0.rsp_ready = 1'b0;
        c1.req_valid = 1'b0; c1.req_addr = 32'h0; c1.req_wen = 1'b0; c1.req_wdata = 32'h0;
        c1.req_wmask = 8'h0; c1.rsp_ready = 1'b1;

        @(negedge clk);
        memLoaded = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", {a1.req_ready, a0.req_ready}, 0);
        checkOutput("rst_rsp_valid", {a1.rsp_valid, a0.rsp_valid}, 0);
        checkOutput("rst_mem_valid", {memA_wen, memA_valid}, 0);
        checkOutput("rst_raddr", memA_raddr, 0);
        checkOutput("rst_wmask", memA_wmask, 0);
        checkOutput("rst_rdata", a0.rsp_rdata, 0);
        rst_n = 1'b1;

        $display("[TB] single port-0 read");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'h0);
        #1;
        checkOutput("t1_ready0", a0.req_ready, 1);
        checkOutput("t1_ready1", a1.req_ready, 0);
        @(negedge clk);
        checkOutput("t1_mem_valid", memA_valid, 1);
        checkOutput("t1_mem_wen", memA_wen, 0);
        checkOutput("t1_raddr", memA_raddr, 32'h8000_0000);
        checkOutput("t1_ready_busy", a0.req_ready, 0);
        checkOutput("t1_rsp_early", a0.rsp_valid, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        @(negedge clk);
        checkOutput("t1_mem_pulse_end", memA_valid, 0);
        checkOutput("t1_rsp_valid", a0.rsp_valid, 1);
        checkOutput("t1_rsp_rdata", a0.rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("t1_rsp1_quiet", a1.rsp_valid, 0);
        @(negedge clk);
        checkOutput("t1_rsp_done", a0.rsp_valid, 0);

        $display("[TB] port-1 write then read back");
        applyStimulus(1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h1234_5678, 8'h0F);
        #1;
        checkOutput("t2_ready1", a1.req_ready, 1);
        checkOutput("t2_ready0", a0.req_ready, 0);
        @(negedge clk);
        checkOutput("t2_mem_valid", memA_valid, 1);
        checkOutput("t2_mem_wen", memA_wen, 1);
        checkOutput("t2_wmask", memA_wmask, 8'h0F);
        checkOutput("t2_wdata", memA_wdata, 32'h1234_5678);
        checkOutput("t2_waddr", memA_waddr, 32'h8000_0010);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        @(negedge clk);
        checkOutput("t2_wr_rsp_valid", a1.rsp_valid, 1);
        checkOutput("t2_wr_rsp_old", a1.rsp_rdata, 32'h4444_4444);
        checkOutput("t2_wr_rsp0_quiet", a0.rsp_valid, 0);
        applyStimulus(1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 8'h0);
        #1;
        checkOutput("t2_ready_in_resp", a1.req_ready, 0);
        @(negedge clk);
        checkOutput("t2_rd_ready", a1.req_ready, 1);
        @(negedge clk);
        checkOutput("t2_rd_mem_valid", memA_valid, 1);
        checkOutput("t2_rd_mem_wen", memA_wen, 0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        @(negedge clk);
        checkOutput("t2_rd_rsp_valid", a1.rsp_valid, 1);
        checkOutput("t2_rd_merged", a1.rsp_rdata, 32'h1234_5678);
        @(negedge clk);
        checkOutput("t2_rd_rsp_done", a1.rsp_valid, 0);
        @(negedge clk);

        $display("[TB] contention: A round-robin, B fixed priority");
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'h0);
        applyStimulus(1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 8'h0);
        b0.req_valid = 1'b1; b0.req_addr = 32'h8000_0000;
        b1.req_valid = 1'b1; b1.req_addr = 32'h8000_0010;
        gA = 0; gB = 0; cyc = 0; prevA = 1'b0; prevB = 1'b0;
        while ((gA < 6 || gB < 6) && cyc < 60) begin
            #1;
            if (a0.req_ready || a1.req_ready) begin
                checkOutput("rr_a_onehot", {31'd0, a0.req_ready & a1.req_ready}, 0);
                checkOutput("rr_a_grant", a1.req_ready, gA % 2);
                gA++;
            end
            if (b0.req_ready || b1.req_ready) begin
                checkOutput("rr_b_onehot", {31'd0, b0.req_ready & b1.req_ready}, 0);
                checkOutput("rr_b_grant", b1.req_ready, 1);
                gB++;
            end
            if (memA_valid) checkOutput("rr_a_gap", prevA, 0);
            if (memB_valid) checkOutput("rr_b_gap", prevB, 0);
            prevA = memA_valid;
            prevB = memB_valid;
            if (a0.rsp_valid) checkOutput("rr_a_rdata0", a0.rsp_rdata, 32'hDEAD_BEEF);
            if (a1.rsp_valid) checkOutput("rr_a_rdata1", a1.rsp_rdata, 32'h1234_5678);
            if (b1.rsp_valid) checkOutput("rr_b_rdata1", b1.rsp_rdata, 32'hC0DE_0010);
            checkOutput("rr_b_rsp0_quiet", b0.rsp_valid, 0);
            cyc++;
            @(negedge clk);
        end
        checkOutput("rr_timeout", {31'd0, cyc < 60}, 1);
        checkOutput("rr_a_count", gA, 6);
        checkOutput("rr_b_count", gB, 6);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] DELAY=3 with stalled response");
        c0.req_valid = 1'b1; c0.req_addr = 32'h8000_0020;
        #1;
        checkOutput("t4_ready", c0.req_ready, 1);
        @(negedge clk);
        checkOutput("t4_mem_valid", memC_valid, 1);
        c0.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t4_wait_rsp", c0.rsp_valid, 0);
            checkOutput("t4_wait_mem", memC_valid, 0);
        end
        @(negedge clk);
        checkOutput("t4_rsp_at_t5", c0.rsp_valid, 1);
        c0.req_valid = 1'b1; c0.req_addr = 32'h8000_0024;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checkOutput("t4_stall_valid", c0.rsp_valid, 1);
            checkOutput("t4_stall_rdata", c0.rsp_rdata, 32'hC0DE_0020);
            checkOutput("t4_stall_ready", c0.req_ready, 0);
        end
        @(negedge clk);
        c0.rsp_ready = 1'b1;
        #1;
        checkOutput("t4_hs_rsp_valid", c0.rsp_valid, 1);
        checkOutput("t4_hs_req_ready", c0.req_ready, 0);
        @(negedge clk);
        checkOutput("t4_after_rsp", c0.rsp_valid, 0);
        checkOutput("t4_next_ready", c0.req_ready, 1);
        @(negedge clk);
        checkOutput("t4_next_mem_valid", memC_valid, 1);
        checkOutput("t4_next_raddr", memC_raddr, 32'h8000_0024);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        c1.req_valid = 1'b1; c1.req_addr = 32'h8000_0030;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_rsp_valid", c0.rsp_valid, 0);
        checkOutput("t5_rst_mem_valid", memC_valid, 0);
        checkOutput("t5_rst_ready", {c1.req_ready, c0.req_ready}, 0);
        repeat (2) @(negedge clk);
        checkOutput("t5_hold_ready", {c1.req_ready, c0.req_ready}, 0);
        checkOutput("t5_hold_rsp", {c1.rsp_valid, c0.rsp_valid}, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("t5_tie_ready0", c0.req_ready, 1);
        checkOutput("t5_tie_ready1", c1.req_ready, 0);
        @(negedge clk);
        checkOutput("t5_mem_valid", memC_valid, 1);
        checkOutput("t5_raddr", memC_raddr, 32'h8000_0024);
        c0.req_valid = 1'b0;
        c1.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t5_wait_rsp", c0.rsp_valid, 0);
        end
        @(negedge clk);
        checkOutput("t5_rsp_valid", c0.rsp_valid, 1);
        checkOutput("t5_rsp_rdata", c0.rsp_rdata, 32'hC0DE_0024);
        checkOutput("t5_rsp1_quiet", c1.rsp_valid, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
